// File: rtl/div_operand_prep.sv
// div_operand_prep
//   Operand stage in front of the unsigned divide core. Each accepted
//   dividend/divisor pair is turned into two magnitudes plus sign and
//   exception flags. The result is queued in a DEPTH-entry FIFO so the core
//   can stall without losing operands.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake (in_ready = count < DEPTH)
//   in_dividend, in_divisor  raw operands, two's complement when in_s=1
//   in_s                     1 = signed, 0 = unsigned
//   out_valid/out_ready      result handshake for the FIFO head
//   out_dvd_mag/out_dvs_mag  operand magnitudes (all outputs are 0 when empty)
//   out_q_neg/out_r_neg      quotient / remainder must be negated
//   out_div_zero, out_ovf    divisor zero, signed quotient overflow
//   count                    FIFO occupancy
//   err_drop                 one-cycle pulse when a zero-divisor pair is dropped
//
// Build option
//   DIV_OPERAND_ZERO_DROP_EN: accepted pairs with a zero divisor are consumed
//   but never enqueued, and err_drop pulses instead. Without the macro they
//   are enqueued with out_div_zero=1 and err_drop is tied 0.

module div_operand_prep #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_dividend,
    input  logic [WIDTH-1:0]           in_divisor,
    input  logic                       in_s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_dvd_mag,
    output logic [WIDTH-1:0]           out_dvs_mag,
    output logic                       out_q_neg,
    output logic                       out_r_neg,
    output logic                       out_div_zero,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] dvd_mag;
        logic [WIDTH-1:0] dvs_mag;
        logic             q_neg;
        logic             r_neg;
        logic             div_zero;
        logic             ovf;
    } entry_t;

    // ---------------- operand conversion ----------------
    logic   dvd_neg, dvs_neg, div_zero, is_min, is_m1;
    entry_t entry_in;

    assign dvd_neg  = in_s & in_dividend[WIDTH-1];
    assign dvs_neg  = in_s & in_divisor[WIDTH-1];
    assign div_zero = (in_divisor == '0);
    assign is_min   = (in_dividend == {1'b1, {(WIDTH-1){1'b0}}});
    assign is_m1    = (in_divisor == {WIDTH{1'b1}});

    always_comb begin
        // The most negative value negates to itself, which read as unsigned
        // is exactly its magnitude (2^(WIDTH-1)), so no extra bit is needed.
        entry_in.dvd_mag  = dvd_neg ? WIDTH'(~in_dividend + 1'b1) : in_dividend;
        entry_in.dvs_mag  = dvs_neg ? WIDTH'(~in_divisor + 1'b1) : in_divisor;
        entry_in.q_neg    = (dvd_neg ^ dvs_neg) & ~div_zero;
        entry_in.r_neg    = dvd_neg;
        entry_in.div_zero = div_zero;
        entry_in.ovf      = in_s & is_min & is_m1;
    end

    // ---------------- FIFO control ----------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, wr;
    entry_t        mem_q [DEPTH];
    entry_t        head;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef DIV_OPERAND_ZERO_DROP_EN
    logic err_drop_q;

    assign wr       = push & ~div_zero;
    assign err_drop = err_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_drop_q <= 1'b0;
        else     err_drop_q <= push & div_zero;
    end
`else
    assign wr       = push;
    assign err_drop = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;   // wraps modulo DEPTH
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every output is gated by out_valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= entry_in;
    end

    // ---------------- outputs ----------------
    assign head  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

    assign out_dvd_mag  = head.dvd_mag;
    assign out_dvs_mag  = head.dvs_mag;
    assign out_q_neg    = head.q_neg;
    assign out_r_neg    = head.r_neg;
    assign out_div_zero = head.div_zero;
    assign out_ovf      = head.ovf;

endmodule

// File: tb/tb_div_operand_prep.sv
// Bench for div_operand_prep: scoreboard of expected entries filled on each
// accepted pair and drained on each pop, plus directed checks for reset,
// conversion corner cases, backpressure and divide-by-zero handling.

module tb_div_operand_prep;

    localparam int W = 9;
    localparam int D = 2;
    localparam int CW = $clog2(D) + 1;

    typedef struct packed {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         qn;
        logic         rn;
        logic         dz;
        logic         ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_dividend = '0;
    logic [W-1:0]  in_divisor = '0;
    logic          in_s = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_dvd_mag, out_dvs_mag;
    logic          out_q_neg, out_r_neg, out_div_zero, out_ovf;
    logic [CW-1:0] count;
    logic          err_drop;

    div_operand_prep #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dvd_mag(out_dvd_mag), .out_dvs_mag(out_dvs_mag),
        .out_q_neg(out_q_neg), .out_r_neg(out_r_neg),
        .out_div_zero(out_div_zero), .out_ovf(out_ovf),
        .count(count), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];
    int   mcount = 0;
    logic exp_drop = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference conversion from integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t m;
        int   da, db;
        da    = s ? int'($signed(a)) : int'(a);
        db    = s ? int'($signed(b)) : int'(b);
        m.dvd = W'(da < 0 ? -da : da);
        m.dvs = W'(db < 0 ? -db : db);
        m.dz  = (db == 0);
        m.qn  = s && ((da < 0) != (db < 0)) && (db != 0);
        m.rn  = s && (da < 0);
        m.ovf = s && (da == -(1 << (W-1))) && (db == -1);
        return m;
    endfunction

    // Monitor: inputs only change at posedge+1, so values seen at negedge
    // are exactly what the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e, o;
            logic p, q;
            chk("count", count, mcount);
            chk("in_ready", in_ready, mcount < D);
            chk("out_valid", out_valid, mcount != 0);
            chk("err_drop", err_drop, exp_drop);
            o = '{out_dvd_mag, out_dvs_mag, out_q_neg, out_r_neg, out_div_zero, out_ovf};
            p = in_valid && in_ready;
            q = out_valid && out_ready;
            if (!out_valid) chk("idle_outputs_zero", o, 0);
            if (q) begin
                if (sb.size() == 0) chk("pop_with_empty_scoreboard", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("head_entry", o, e);
                end
            end
            exp_drop = 1'b0;
            if (p) begin
                e = model(in_dividend, in_divisor, in_s);
`ifdef DIV_OPERAND_ZERO_DROP_EN
                if (e.dz) exp_drop = 1'b1;
                else sb.push_back(e);
`else
                sb.push_back(e);
`endif
            end
            mcount = mcount + ((p && !(exp_drop)) ? 1 : 0) - (q ? 1 : 0);
        end
    end

    // Present a pair and hold it until it is accepted; leaves in_valid high
    // so back-to-back calls stream without a bubble.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic acc;
        in_valid = 1'b1; in_dividend = a; in_divisor = b; in_s = s;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!out_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        // power-on reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // signed conversion
        send(9'h1F9, 9'd2, 1'b1); idle();
        @(negedge clk);
        chk("sgn_dvd", out_dvd_mag, 7);
        chk("sgn_dvs", out_dvs_mag, 2);
        chk("sgn_qneg", out_q_neg, 1);
        chk("sgn_rneg", out_r_neg, 1);
        chk("sgn_dz", out_div_zero, 0);
        chk("sgn_ovf", out_ovf, 0);
        drain();

        // overflow: -256 / -1
        send(9'h100, 9'h1FF, 1'b1); idle();
        @(negedge clk);
        chk("ovf_dvd", out_dvd_mag, 256);
        chk("ovf_dvs", out_dvs_mag, 1);
        chk("ovf_qneg", out_q_neg, 0);
        chk("ovf_flag", out_ovf, 1);
        drain();

        // unsigned keeps raw bits
        send(9'h1F9, 9'd2, 1'b0); idle();
        @(negedge clk);
        chk("uns_dvd", out_dvd_mag, 505);
        chk("uns_qneg", out_q_neg, 0);
        chk("uns_ovf", out_ovf, 0);
        drain();

        // divide by zero
        send(9'd5, 9'd0, 1'b1); idle();
        @(negedge clk);
`ifdef DIV_OPERAND_ZERO_DROP_EN
        chk("dz_drop_count", count, 0);
        chk("dz_drop_pulse", err_drop, 1);
        @(negedge clk);
        chk("dz_drop_pulse_end", err_drop, 0);
`else
        chk("dz_flag", out_div_zero, 1);
        chk("dz_qneg", out_q_neg, 0);
        chk("dz_rneg", out_r_neg, 0);
        chk("dz_no_pulse", err_drop, 0);
`endif
        drain();

        // backpressure: third pair waits until a slot frees
        send(9'd10, 9'd3, 1'b1);
        send(9'h1F0, 9'd4, 1'b1);
        fork
            send(9'd33, 9'h1FD, 1'b1);
            begin
                @(negedge clk);
                chk("bp_full_ready", in_ready, 0);
                chk("bp_full_count", count, D);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // streaming with simultaneous push/pop at count=1, wraps pointers
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send(W'($urandom_range(1, (1 << W) - 1)), W'($urandom_range(1, (1 << W) - 1)), 1'($urandom_range(0, 1)));
        idle();
        drain();

        // asynchronous reset mid-cycle with two entries queued
        send(9'd20, 9'd5, 1'b0);
        send(9'h1EC, 9'd5, 1'b1);
        idle();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_outputs", {out_dvd_mag, out_dvs_mag, out_q_neg, out_r_neg, out_div_zero, out_ovf}, 0);
        chk("arst_err_drop", err_drop, 0);
        sb.delete();
        mcount = 0;
        exp_drop = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // post-reset traffic still flows in order
        out_ready = 1'b1;
        send(9'd100, 9'd7, 1'b1);
        send(9'h180, 9'h1FE, 1'b1);
        idle();
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
